// File: rtl/exu_redirect_ctrl.sv
// Front-end redirect sequencer: arbitrates branch, trap and fence redirects,
// holds the winner until the IFU takes it, then runs a fixed flush window.
module exu_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bru_req_i,
  input  logic [ADDR_W-1:0] bru_addr_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              fence_req_i,
  input  logic [ADDR_W-1:0] fence_addr_i,
  input  logic              ifu_ready_i,
  output logic              bru_ack_o,
  output logic              trap_ack_o,
  output logic              fence_ack_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic [1:0]        redirect_src_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  redirect_cnt_o
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_BRU   = 2'b01;
  localparam logic [1:0] SRC_TRAP  = 2'b10;
  localparam logic [1:0] SRC_FENCE = 2'b11;
  localparam logic [3:0] FLUSH_LD  = 4'(FLUSH_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [1:0]        src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_inc;
  logic              bru_take, trap_take, fence_take;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    src_d      = src_q;
    addr_d     = addr_q;
    cnt_inc    = 1'b0;
    bru_take   = 1'b0;
    trap_take  = 1'b0;
    fence_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap_req_i) begin
          trap_take = 1'b1;
          src_d     = SRC_TRAP;
          addr_d    = trap_addr_i;
          state_d   = REDIRECT;
        end else if (bru_req_i) begin
          bru_take  = 1'b1;
          src_d     = SRC_BRU;
          addr_d    = bru_addr_i;
          state_d   = REDIRECT;
        end else if (fence_req_i) begin
          fence_take = 1'b1;
          src_d      = SRC_FENCE;
          addr_d     = fence_addr_i;
          state_d    = REDIRECT;
        end
      end
      REDIRECT: begin
        if (ifu_ready_i) begin
          cnt_inc = 1'b1;
          fcnt_d  = FLUSH_LD;
          state_d = (FLUSH_LD == 4'd0) ? IDLE : FLUSH;
        end else if (trap_req_i && (src_q != SRC_TRAP)) begin
          // A trap displaces a pending bru/fence target; the loser is dropped.
          trap_take = 1'b1;
          src_d     = SRC_TRAP;
          addr_d    = trap_addr_i;
        end
      end
      FLUSH: begin
        if (trap_req_i) begin
          trap_take = 1'b1;
          src_d     = SRC_TRAP;
          addr_d    = trap_addr_i;
          fcnt_d    = 4'd0;
          state_d   = REDIRECT;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
          if (fcnt_q <= 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
      src_q   <= SRC_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      src_q   <= src_d;
      if (cnt_inc) cnt_q <= sat_inc(cnt_q);
    end
  end

  // Target address is data only; it is masked off whenever no redirect is offered.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign bru_ack_o        = bru_take & ~rst;
  assign trap_ack_o       = trap_take & ~rst;
  assign fence_ack_o      = fence_take & ~rst;
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_addr_o  = redirect_valid_o ? addr_q : '0;
  assign redirect_src_o   = redirect_valid_o ? src_q : SRC_NONE;
  assign flush_o          = (state_q == REDIRECT) | (state_q == FLUSH);
  assign stall_o          = (state_q != IDLE);
  assign redirect_cnt_o   = cnt_q;

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Bench for exu_redirect_ctrl: a default build and a FLUSH_CYCLES=0/CNT_W=4 build,
// both compared every cycle against an offer/flush-window reference model.
module tb_exu_redirect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: bru, 1: trap, 2: fence
  logic [1:0]             rst;
  logic [1:0]             rdy;
  logic [1:0][2:0]        req;
  logic [1:0][2:0][31:0]  raddr;
  logic [1:0][2:0]        ack;
  logic [1:0]             vld, fl, st;
  logic [1:0][31:0]       aout;
  logic [1:0][1:0]        sout;
  logic [15:0]            cnt0;
  logic [3:0]             cnt1;

  exu_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst[0]),
    .bru_req_i(req[0][0]), .bru_addr_i(raddr[0][0]),
    .trap_req_i(req[0][1]), .trap_addr_i(raddr[0][1]),
    .fence_req_i(req[0][2]), .fence_addr_i(raddr[0][2]),
    .ifu_ready_i(rdy[0]),
    .bru_ack_o(ack[0][0]), .trap_ack_o(ack[0][1]), .fence_ack_o(ack[0][2]),
    .redirect_valid_o(vld[0]), .redirect_addr_o(aout[0]), .redirect_src_o(sout[0]),
    .flush_o(fl[0]), .stall_o(st[0]), .redirect_cnt_o(cnt0)
  );

  exu_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst[1]),
    .bru_req_i(req[1][0]), .bru_addr_i(raddr[1][0]),
    .trap_req_i(req[1][1]), .trap_addr_i(raddr[1][1]),
    .fence_req_i(req[1][2]), .fence_addr_i(raddr[1][2]),
    .ifu_ready_i(rdy[1]),
    .bru_ack_o(ack[1][0]), .trap_ack_o(ack[1][1]), .fence_ack_o(ack[1][2]),
    .redirect_valid_o(vld[1]), .redirect_addr_o(aout[1]), .redirect_src_o(sout[1]),
    .flush_o(fl[1]), .stall_o(st[1]), .redirect_cnt_o(cnt1)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: an offered redirect (if any) and the flush cycles still owed.
  bit          m_off [2];
  int          m_src [2];
  logic [31:0] m_addr[2];
  int          m_fl  [2];
  int          m_cnt [2];
  int          fc    [2] = '{2, 0};
  int          cmax  [2] = '{65535, 15};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic [1:0][2:0] eack;
    string p;
    #1;
    for (int i = 0; i < 2; i++) begin
      bit idle = !m_off[i] && (m_fl[i] == 0);
      eack[i] = 3'b000;
      if (!rst[i]) begin
        if (idle) begin
          if (req[i][1])      eack[i][1] = 1'b1;
          else if (req[i][0]) eack[i][0] = 1'b1;
          else if (req[i][2]) eack[i][2] = 1'b1;
        end else if (m_off[i]) begin
          if (req[i][1] && !rdy[i] && m_src[i] != 2) eack[i][1] = 1'b1;
        end else if (req[i][1]) begin
          eack[i][1] = 1'b1;
        end
      end
      p = $sformatf("u%0d_", i);
      chk({p, "bru_ack"},   32'(ack[i][0]), 32'(eack[i][0]));
      chk({p, "trap_ack"},  32'(ack[i][1]), 32'(eack[i][1]));
      chk({p, "fence_ack"}, 32'(ack[i][2]), 32'(eack[i][2]));
      chk({p, "valid"},     32'(vld[i]),    32'(m_off[i]));
      chk({p, "addr"},      aout[i],        m_off[i] ? m_addr[i] : 32'h0);
      chk({p, "src"},       32'(sout[i]),   m_off[i] ? 32'(m_src[i]) : 32'h0);
      chk({p, "flush"},     32'(fl[i]),     32'(m_off[i] || m_fl[i] > 0));
      chk({p, "stall"},     32'(st[i]),     32'(m_off[i] || m_fl[i] > 0));
      chk({p, "cnt"},       (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_cnt[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_off[i] = 0; m_fl[i] = 0; m_cnt[i] = 0;
      end else if (|eack[i]) begin
        for (int r = 0; r < 3; r++)
          if (eack[i][r]) begin
            m_off[i] = 1; m_src[i] = r + 1; m_addr[i] = raddr[i][r]; m_fl[i] = 0;
          end
      end else if (m_off[i] && rdy[i]) begin
        m_off[i] = 0;
        if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        m_fl[i] = fc[i];
      end else if (m_fl[i] > 0) begin
        m_fl[i]--;
      end
    end
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 3; r++)
        if (eack[i][r]) req[i][r] = 1'b0;
  endtask

  task automatic gen(input int i);
    for (int r = 0; r < 3; r++)
      if (!req[i][r] && $urandom_range(0, 3) == 0) begin
        req[i][r]   = 1'b1;
        raddr[i][r] = $urandom;
      end
    rdy[i] = ($urandom_range(0, 2) != 0);
    rst[i] = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    rst = 2'b11; rdy = '0; req = '0; raddr = '0;
    for (int i = 0; i < 2; i++) begin
      m_off[i] = 0; m_src[i] = 0; m_addr[i] = '0; m_fl[i] = 0; m_cnt[i] = 0;
    end
    @(negedge clk);
    step(); step();
    rst = 2'b00;
    chk("reset_cnt", 32'(cnt0), 32'h0);

    // Single branch redirect with IFU always ready
    req[0][0] = 1'b1; raddr[0][0] = 32'h8000_0100; rdy[0] = 1'b1;
    repeat (5) step();
    chk("s1_cnt", 32'(cnt0), 32'd1);
    chk("s1_stall", 32'(st[0]), 32'd0);

    // All three at once: trap first, then bru, then fence
    req[0] = 3'b111;
    raddr[0][1] = 32'h8000_0004; raddr[0][0] = 32'h8000_0100; raddr[0][2] = 32'h8000_0200;
    for (int k = 0; k < 40 && req[0] != 3'b000; k++) step();
    repeat (4) step();
    chk("s2_cnt", 32'(cnt0), 32'd4);

    // IFU stalls five cycles while a redirect is offered
    req[0][0] = 1'b1; raddr[0][0] = 32'h1234_5678; rdy[0] = 1'b0;
    step();
    repeat (5) step();
    rdy[0] = 1'b1;
    repeat (4) step();
    chk("s3_cnt", 32'(cnt0), 32'd5);

    // Trap preempts a pending fence
    req[0][2] = 1'b1; raddr[0][2] = 32'h8000_0200; rdy[0] = 1'b0;
    step(); step();
    req[0][1] = 1'b1; raddr[0][1] = 32'h8000_0004;
    step();
    #1;
    chk("s4_addr", aout[0], 32'h8000_0004);
    chk("s4_src", 32'(sout[0]), 32'd2);
    step();
    rdy[0] = 1'b1;
    repeat (4) step();
    chk("s4_cnt", 32'(cnt0), 32'd6);

    // Reset while a redirect is offered, with a bru request held across it
    req[0][0] = 1'b1; raddr[0][0] = 32'h8000_0100; rdy[0] = 1'b0;
    step(); step();
    rst[0] = 1'b1; req[0][0] = 1'b1; raddr[0][0] = 32'h8000_0300;
    step();
    rst[0] = 1'b0;
    #1;
    chk("s5_valid", 32'(vld[0]), 32'd0);
    chk("s5_stall", 32'(st[0]), 32'd0);
    step();
    rdy[0] = 1'b1;
    repeat (4) step();
    chk("s5_cnt", 32'(cnt0), 32'd1);

    // Randomized traffic on both builds
    repeat (3000) begin
      gen(0); gen(1);
      step();
    end

    // Saturation of the 4-bit counter with zero-length flush
    rst = 2'b11; req = '0;
    step();
    rst = 2'b00; rdy = 2'b00;
    rdy[1] = 1'b1;
    repeat (40) begin
      req[1][0] = 1'b1; raddr[1][0] = $urandom;
      step();
    end
    chk("sat_cnt", 32'(cnt1), 32'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exu_redirect_ctrl.md
Name: exu_redirect_ctrl

Overview:
- Sequences all front-end redirects from the execute stage.
- Arbitrates three requesters: branch/jump unit, trap/interrupt logic, and FENCE/FENCE.I refetch.
- Holds the winning target until the fetch unit accepts it, then drives a fixed-length pipeline flush window.
- Sits between the EXU (branch unit, CSR/trap unit) and the IFU PC-select logic; replaces direct jump_flag/jump_addr wiring into the IFU.

Parameters:
ADDR_W, 32, width of all redirect addresses.
FLUSH_CYCLES, 2, cycles flush_o remains high after the IFU accepts a redirect (0..15).
CNT_W, 16, width of the completed-redirect counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
bru_req_i  input  1  branch unit redirect request (jump, rollback); held until acked
bru_addr_i  input  ADDR_W  branch unit target
trap_req_i  input  1  trap/interrupt redirect request; held until acked
trap_addr_i  input  ADDR_W  trap vector / mret target
fence_req_i  input  1  fence refetch request; held until acked
fence_addr_i  input  ADDR_W  refetch PC (fence PC+4)
ifu_ready_i  input  1  IFU accepts redirect this cycle
bru_ack_o  output  1  one-cycle pulse: bru request captured
trap_ack_o  output  1  one-cycle pulse: trap request captured
fence_ack_o  output  1  one-cycle pulse: fence request captured
redirect_valid_o  output  1  redirect offered to IFU
redirect_addr_o  output  ADDR_W  redirect target
redirect_src_o  output  2  00 none, 01 bru, 10 trap, 11 fence
flush_o  output  1  kill younger instructions in IF/ID/EX
stall_o  output  1  block EXU issue while controller busy
redirect_cnt_o  output  CNT_W  saturating count of completed handshakes

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high. All outputs reset to 0; state IDLE; flush counter 0. Reset mid-operation abandons any pending redirect; no ack is issued in the reset cycle.
- States: IDLE, REDIRECT, FLUSH.
- IDLE:
  - Fixed priority trap > bru > fence.
  - If any request is high, the winner's ack pulses in the same cycle (combinational), and its addr/src are registered. Next state REDIRECT.
  - Losers are not acked and must hold their request.
- REDIRECT:
  - redirect_valid_o=1; addr/src stable until the handshake.
  - Handshake = redirect_valid_o & ifu_ready_i. On handshake: redirect_cnt_o += 1 (saturates at all-ones). Next state is FLUSH, loading the counter with FLUSH_CYCLES; if FLUSH_CYCLES==0, next state is IDLE.
  - Trap preemption: if trap_req_i=1, no handshake this cycle, and the current src≠trap, then trap_ack_o pulses, addr/src are replaced by the trap values, and the state stays REDIRECT. The displaced bru/fence redirect is dropped without a second ack.
  - A trap arriving in the same cycle as a handshake is not acked; it is taken in FLUSH.
  - bru/fence requests in REDIRECT are never acked.
- FLUSH:
  - redirect_valid_o=0; the counter decrements each cycle; exit to IDLE when the counter reaches 1→0.
  - trap_req_i in FLUSH: ack immediately, capture, go to REDIRECT (the flush restarts after the new handshake).
  - bru/fence requests in FLUSH are ignored.
- flush_o = (state==REDIRECT) | (state==FLUSH).
- stall_o = state≠IDLE.
- redirect_src_o = 00 in IDLE and FLUSH.
- Acks are mutually exclusive; at most one ack per cycle.
- Addresses pass through unmodified. No alignment checking; misalignment is flagged upstream.
- Latency from request to redirect_valid_o: 1 cycle. Minimum request-to-request spacing for non-trap requesters: 2 + FLUSH_CYCLES cycles with ifu_ready_i held high.

Test Plan:
- Reset, then bru_req_i=1 with addr 0x8000_0100 and ifu_ready_i=1 → cycle 0 bru_ack_o=1; cycle 1 valid=1, addr=0x8000_0100, src=01, flush=1; cycles 2-3 flush=1, valid=0; cycle 4 stall=0; cnt=1.
- Simultaneous trap (0x8000_0004), bru, and fence requests in IDLE → only trap_ack_o; src=10. bru acked after the trap flush window ends, then fence after that; cnt=3.
- ifu_ready_i=0 for 5 cycles while in REDIRECT → valid, addr, and flush held stable for all 5 cycles; handshake on cycle 6; no extra acks.
- Pending fence redirect (0x8000_0200, ifu_ready_i=0), then trap_req_i to 0x8000_0004 → trap_ack_o pulses; addr becomes 0x8000_0004, src=10; fence is never acked again.
- rst asserted for one cycle while in REDIRECT → next cycle all outputs 0 and state IDLE; a held bru request is acked on the first cycle after rst deasserts.
- FLUSH_CYCLES=0 and cnt preloaded near saturation via 2^CNT_W handshakes (CNT_W=4 build) → state returns to IDLE the cycle after each handshake; cnt stops at 0xF.
